// File: rtl/axi_mem_slave_pkg.sv
// Shared types for the AXI4 memory responder: burst encodings, response
// codes, channel state enums and the per-direction burst descriptor.
package axi_mem_slave_pkg;

    // Project-wide AXI widths; the descriptor is sized from these.
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_t;

    // Burst kept as raw bits so the reserved encoding 2'b11 can be held
    // and flagged as an error.
    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic [7:0]                beat;
    } burst_desc_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational burst address step, word index and error detection for one
// AXI channel. Optional feature macro: AXI_MEM_SLAVE_WRAP_EN enables WRAP
// bursts; without it every WRAP burst is reported as an error.
module axi_burst_addr_gen
    import axi_mem_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [7:0]                   len_i,
    input  logic [2:0]                   size_i,
    input  logic [1:0]                   burst_i,
    output logic [ADDR_WIDTH-1:0]        next_addr_o,
    output logic [$clog2(MEM_DEPTH)-1:0] idx_o,
    output logic                         burst_err_o,
    output logic                         oor_o
);

    localparam int SIZE_MAX = $clog2(STRB_WIDTH);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB_WIDTH);

    logic [ADDR_WIDTH-1:0] incr;
`ifdef AXI_MEM_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] wrap_mask;
`endif

    assign idx_o = addr_i[SIZE_MAX +: IDX_W];
    assign oor_o = ({1'b0, addr_i} >= LIMIT);

    // Next beat address and burst legality for the current descriptor.
    always_comb begin
        incr        = ADDR_WIDTH'(1) << size_i;
        next_addr_o = addr_i + incr;
        burst_err_o = (int'(size_i) > SIZE_MAX) || (burst_i == 2'b11);
`ifdef AXI_MEM_SLAVE_WRAP_EN
        size_mask   = incr - ADDR_WIDTH'(1);
        wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
`endif
        if (burst_i == BURST_FIXED) begin
            next_addr_o = addr_i;
        end else if (burst_i == BURST_WRAP) begin
`ifdef AXI_MEM_SLAVE_WRAP_EN
            // Low bits step within the (len+1)<<size window, high bits stay at the aligned base.
            next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + incr) & wrap_mask);
            if (!(len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((addr_i & size_mask) != '0)) begin
                burst_err_o = 1'b1;
            end
`else
            burst_err_o = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a register-file memory. Independent write and
// read FSMs share the array; one outstanding burst per direction.
// Optional feature macro: AXI_MEM_SLAVE_WRAP_EN (WRAP burst support).
module axi_mem_slave
    import axi_mem_slave_pkg::*;
#(
    parameter int ID_WIDTH   = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   axi_awid,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [STRB_WIDTH-1:0] axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [ID_WIDTH-1:0]   axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    input  logic [ID_WIDTH-1:0]   axi_arid,
    input  logic [ADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [ID_WIDTH-1:0]   axi_rid,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    wr_state_t   wstate_q, wstate_d;
    burst_desc_t wdesc_q, wdesc_d;
    logic        werr_q, werr_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        mem_we;

    logic [ADDR_WIDTH-1:0] wnext_addr;
    logic [IDX_W-1:0]      widx;
    logic                  wburst_err, woor;

    rd_state_t   rstate_q, rstate_d;
    burst_desc_t rdesc_q, rdesc_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [ADDR_WIDTH-1:0] rnext_addr;
    logic [IDX_W-1:0]      ridx;
    logic                  rburst_err, roor;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_wr_addr (
        .addr_i      (ADDR_WIDTH'(wdesc_q.addr)),
        .len_i       (wdesc_q.len),
        .size_i      (wdesc_q.size),
        .burst_i     (wdesc_q.burst),
        .next_addr_o (wnext_addr),
        .idx_o       (widx),
        .burst_err_o (wburst_err),
        .oor_o       (woor)
    );

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_rd_addr (
        .addr_i      (ADDR_WIDTH'(rdesc_q.addr)),
        .len_i       (rdesc_q.len),
        .size_i      (rdesc_q.size),
        .burst_i     (rdesc_q.burst),
        .next_addr_o (rnext_addr),
        .idx_o       (ridx),
        .burst_err_o (rburst_err),
        .oor_o       (roor)
    );

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bid     = bvalid_q ? ID_WIDTH'(wdesc_q.id) : '0;
    assign axi_bresp   = (bvalid_q && werr_q) ? RESP_SLVERR : RESP_OKAY;

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rlast   = rlast_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;
    assign axi_rid     = rvalid_q ? ID_WIDTH'(rdesc_q.id) : '0;

    // Write channel next-state: capture AW, accept beats, hold B until taken.
    always_comb begin
        wstate_d  = wstate_q;
        wdesc_d   = wdesc_q;
        werr_d    = werr_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        mem_we    = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi_awvalid && awready_q) begin
                    wdesc_d.id    = AXI_ID_WIDTH'(axi_awid);
                    wdesc_d.addr  = AXI_ADDR_WIDTH'(axi_awaddr);
                    wdesc_d.len   = axi_awlen;
                    wdesc_d.size  = axi_awsize;
                    wdesc_d.burst = axi_awburst;
                    wdesc_d.beat  = 8'd0;
                    werr_d        = 1'b0;
                    awready_d     = 1'b0;
                    wready_d      = 1'b1;
                    wstate_d      = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid && wready_q) begin
                    mem_we = !wburst_err && !woor;
                    if (wburst_err || woor || (axi_wlast != (wdesc_q.beat == wdesc_q.len))) begin
                        werr_d = 1'b1;
                    end
                    // The burst ends on the beat count alone; a wrong wlast only marks the error.
                    if (wdesc_q.beat == wdesc_q.len) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        wstate_d = W_RESP;
                    end else begin
                        wdesc_d.beat = wdesc_q.beat + 8'd1;
                        wdesc_d.addr = AXI_ADDR_WIDTH'(wnext_addr);
                    end
                end
            end
            W_RESP: begin
                if (axi_bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write channel state register; the descriptor is left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            werr_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            werr_q    <= werr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
        wdesc_q <= wdesc_d;
    end

    // Byte-strobed memory write; a beat coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (axi_wstrb[b]) begin
                    mem_q[widx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read channel next-state: one fetch cycle then one presentation cycle per beat.
    always_comb begin
        rstate_d  = rstate_q;
        rdesc_d   = rdesc_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid && arready_q) begin
                    rdesc_d.id    = AXI_ID_WIDTH'(axi_arid);
                    rdesc_d.addr  = AXI_ADDR_WIDTH'(axi_araddr);
                    rdesc_d.len   = axi_arlen;
                    rdesc_d.size  = axi_arsize;
                    rdesc_d.burst = axi_arburst;
                    rdesc_d.beat  = 8'd0;
                    arready_d     = 1'b0;
                    rstate_d      = R_FETCH;
                end
            end
            R_FETCH: begin
                // Registered read sees the array before any same-cycle write lands.
                if (rburst_err || roor) begin
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                end else begin
                    rdata_d = mem_q[ridx];
                    rresp_d = RESP_OKAY;
                end
                rlast_d  = (rdesc_q.beat == rdesc_q.len);
                rvalid_d = 1'b1;
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (axi_rready && rvalid_q) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        rdesc_d.beat = rdesc_q.beat + 8'd1;
                        rdesc_d.addr = AXI_ADDR_WIDTH'(rnext_addr);
                        rstate_d     = R_FETCH;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read channel state and output registers; the descriptor is left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
        rdesc_q <= rdesc_d;
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
AXI4 responder (slave) terminating one axi_if port with an internal register-file memory. It accepts write bursts on AW/W and returns B responses, and accepts read bursts on AR and returns R beats. It serves as the endpoint behind the AXI interconnect and as the bench target for initiator-side blocks. Write and read channels are independent FSMs sharing one memory array; at most one outstanding transaction per direction.

Parameters:
ID_WIDTH, 4, transaction ID width (shared project parameter)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data bus width; legal values 32 or 64
STRB_WIDTH, DATA_WIDTH/8, write strobe width
MEM_DEPTH, 1024, memory depth in DATA_WIDTH words

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address channel
axi_awready  out  1  write address ready
axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/STRB_WIDTH/1/1  write data channel
axi_wready  out  1  write data ready
axi_bid/bresp/bvalid  out  ID_WIDTH/2/1  write response
axi_bready  in  1  response ready
axi_arid/araddr/arlen/arsize/arburst/arvalid  in  as AW  read address channel
axi_arready  out  1  read address ready
axi_rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel
axi_rready  in  1  read data ready
Lock, cache, prot, qos and user signals are not connected; user outputs are tied to 0.

Behaviour:
- Reset: all outputs are 0 (awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid, rdata). Both FSMs go to IDLE. Memory contents are not cleared. awready/arready rise 1 cycle after reset deasserts.
- Reset mid-burst aborts the burst. No B or R response is issued for it.
- Word index = addr[log2(STRB_WIDTH) +: log2(MEM_DEPTH)]. Any address >= MEM_DEPTH*STRB_WIDTH is out of range.
- Burst addressing: FIXED keeps the address constant. INCR adds 1<<size per beat. Size > log2(STRB_WIDTH) or burst == 2'b11 is an error.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, capture id/addr/len/size/burst, clear the error flag and beat counter, set awready=0 and wready=1.
  - W_DATA: on each W handshake, write bytes where wstrb=1 into the memory in the same cycle, then advance the address.
  - Error flag sets on any out-of-range beat (that beat's write is dropped), on an illegal size/burst (all writes dropped), or on wlast != (beat==len).
  - After beat len is accepted: wready=0 and go to W_RESP, regardless of wlast.
  - W_RESP: bvalid=1, bid=captured id, bresp=SLVERR (2'b10) if the error flag is set, else OKAY. On bready, bvalid=0 and go to W_IDLE; awready=1 next cycle.
- Read FSM R_IDLE -> R_FETCH -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture the burst and go to R_FETCH.
  - R_FETCH: register rdata from the memory (0 on error or out of range). Set rresp and rlast = (beat==len). Go to R_DATA.
  - R_DATA: rvalid=1, outputs held stable until rready. On handshake, go to R_IDLE if rlast, else advance the address and go to R_FETCH.
  - Latency: AR handshake in cycle T gives the first rvalid in T+2. Peak throughput is one beat every 2 cycles.
- Read and write in the same cycle to the same word: the fetch returns the old data.
- awlen=0 is a single beat; awlen=255 is 256 beats. The beat counter is 8 bits and never wraps within a burst.

Optional Feature:
AXI_MEM_SLAVE_WRAP_EN:
- Defined: WRAP bursts are supported. Legal len is 1, 3, 7 or 15; the wrap boundary is (len+1)<<size and the address wraps to the aligned base. Unaligned start addresses and other lens are errors (SLVERR, writes dropped).
- Undefined: any WRAP burst is an error. All beats complete with SLVERR, no writes, read data 0.

Decomposition:
- Package axi_mem_slave_pkg:
  - burst_t (FIXED 2'b00, INCR 2'b01, WRAP 2'b10)
  - resp constants (OKAY 2'b00, SLVERR 2'b10)
  - write and read state enums
  - burst descriptor struct (id, addr, len, size, burst, beat)
- Sub-module axi_burst_addr_gen: combinational next-address and error detection, instantiated once per channel.

Test Plan:
- Write INCR addr 0x10, len=3, size=2, data 0xA0..0xA3, strb 0xF -> bresp=OKAY, bid echoed; read back the same burst -> rdata 0xA0..0xA3, rlast on beat 3, rresp OKAY.
- Write 0xFFFFFFFF then 0x12345678 to 0x40 with strb 0b0101 -> read returns 0xFF34FF78.
- FIXED write len=2 to 0x20, data 1,2,3 -> read of 0x20 returns 3.
- Write to byte address MEM_DEPTH*4 -> bresp=SLVERR; read of the same address -> rdata 0, rresp=SLVERR.
- Hold bready=0 for 5 cycles and rready=0 for 3 cycles -> bvalid/rvalid and payloads stay stable, awready stays 0; wlast early on beat 1 of len=3 -> SLVERR after 4 beats.
- WRAP len=3 size=2 at 0x38 -> with the macro, beats go to 0x38, 0x3C, 0x30, 0x34 with OKAY; without it, SLVERR on every beat.
